// File: rtl/wdt_kick_sched.sv
// Heartbeat scheduler for an external watchdog: kicks wdi only while every
// supervised requester checks in once per window; mr_n gives a forced reset.
module wdt_kick_sched #(
    parameter int N_REQ       = 4,
    parameter int KICK_PERIOD = 1000,
    parameter int MR_CYC      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_REQ-1:0] req_alive,
    input  logic [N_REQ-1:0] req_mask,
    input  logic             miss_clr,
    input  logic             force_rst,
    input  logic             wdt_rst_n,
    output logic             wdi,
    output logic             mr_n,
    output logic [1:0]       state,
    output logic [N_REQ-1:0] miss,
    output logic [15:0]      kick_cnt
);

    localparam int TW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
    localparam int FW = $clog2(MR_CYC + 1);
    localparam logic [TW-1:0] T_LAST = TW'(KICK_PERIOD - 1);
    localparam logic [FW-1:0] F_LAST = FW'(MR_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BOOT,
        S_RUN,
        S_STARVE,
        S_FORCE
    } fsm_t;

    fsm_t             fsm;
    logic [TW-1:0]    timer;
    logic [N_REQ-1:0] seen;
    logic [FW-1:0]    fcnt;
    logic [1:0]       sync;
    logic             wsync;
    logic [N_REQ-1:0] hit;
    logic             ok;
    logic             term;

    assign wsync = sync[1];
    assign hit   = req_alive & req_mask;
    // Terminal-cycle pulses are excluded: they belong to the next window.
    assign ok    = &(seen | ~req_mask);
    assign term  = (timer == T_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm      <= S_IDLE;
            timer    <= '0;
            seen     <= '0;
            fcnt     <= '0;
            sync     <= '0;
            wdi      <= 1'b0;
            mr_n     <= 1'b1;
            miss     <= '0;
            kick_cnt <= '0;
        end else begin
            sync <= {sync[0], wdt_rst_n};
            if (miss_clr) begin
                miss <= '0;
            end
            if (force_rst && fsm != S_IDLE) begin
                fsm  <= S_FORCE;
                mr_n <= 1'b0;
                fcnt <= F_LAST;
            end else if (!en) begin
                fsm  <= S_IDLE;
                mr_n <= 1'b1;
            end else begin
                case (fsm)
                    S_IDLE: begin
                        fsm <= S_BOOT;
                    end
                    S_BOOT: begin
                        if (wsync) begin
                            fsm   <= S_RUN;
                            timer <= '0;
                            seen  <= '0;
                        end
                    end
                    S_RUN: begin
                        if (!wsync) begin
                            fsm <= S_BOOT;
                        end else if (term) begin
                            if (ok) begin
                                wdi   <= ~wdi;
                                timer <= '0;
                                seen  <= hit;
                                if (kick_cnt != 16'hFFFF) begin
                                    kick_cnt <= kick_cnt + 16'd1;
                                end
                            end else begin
                                // A new miss beats a same-cycle clear.
                                miss <= (miss_clr ? '0 : miss)
                                        | (req_mask & ~seen);
                                fsm  <= S_STARVE;
                            end
                        end else begin
                            timer <= timer + 1'b1;
                            seen  <= seen | hit;
                        end
                    end
                    S_STARVE: begin
                        if (!wsync) begin
                            fsm <= S_BOOT;
                        end
                    end
                    S_FORCE: begin
                        if (fcnt == '0) begin
                            mr_n <= 1'b1;
                            fsm  <= S_BOOT;
                        end else begin
                            fcnt <= fcnt - 1'b1;
                        end
                    end
                    default: begin
                        fsm <= S_IDLE;
                    end
                endcase
            end
        end
    end

    always_comb begin
        state = 2'd0;
        case (fsm)
            S_IDLE:   state = 2'd0;
            S_BOOT:   state = 2'd1;
            S_RUN:    state = 2'd2;
            S_STARVE: state = 2'd3;
            S_FORCE:  state = 2'd1;
            default:  state = 2'd0;
        endcase
    end

endmodule
